// File: rtl/mips32_mem_responder_if.sv
// Fetch + data request/ack bus between core and memory responder.
// master = core side, slave = memory responder side.
interface mips32_mem_responder_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, if_err,
    input  d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, if_err,
    output d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/mips32_mem_responder.sv
// Single-ported DEPTH x 32 memory with round-robin fetch/data arbitration
// and WAIT_CYCLES wait states. Ports: clk, rst_n (sync), mem_if.slave, busy.
module mips32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips32_mem_responder_if.slave mem_if,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_e;

  localparam logic [3:0] WAITS = 4'(WAIT_CYCLES);
  localparam logic P_IF = 1'b0;
  localparam logic P_D  = 1'b1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        port_q, port_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        if_err_q, if_err_d;
  logic        d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic [31:0] mem [DEPTH];

  logic          gnt_port;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          mem_we;

  assign in_range = (addr_q[31:AW] == '0);
  assign idx      = addr_q[AW-1:0];
  assign rd_word  = mem[idx];
  assign mem_we   = (state_q == S_ACCESS) && we_q && in_range;

  // On a tie, grant whichever port did not win last time.
  always_comb begin
    gnt_port = P_IF;
    unique case (1'b1)
      mem_if.d_req && mem_if.if_req:  gnt_port = ~last_q;
      mem_if.d_req && !mem_if.if_req: gnt_port = P_D;
      default:                        gnt_port = P_IF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_if.d_req || mem_if.if_req) begin
          port_d  = gnt_port;
          last_d  = gnt_port;
          addr_d  = gnt_port ? mem_if.d_addr : mem_if.if_addr;
          we_d    = gnt_port & mem_if.d_we;
          wdata_d = mem_if.d_wdata;
          cnt_d   = WAITS;
          state_d = (WAITS == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Response registers load in ACCESS and so are valid during DONE only.
  always_comb begin
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_err_d   = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = '0;
    d_rdata_d  = '0;
    if (state_q == S_ACCESS) begin
      if (port_q == P_D) begin
        d_ack_d   = 1'b1;
        d_err_d   = !in_range;
        d_rdata_d = (in_range && !we_q) ? rd_word : '0;
      end else begin
        if_ack_d   = 1'b1;
        if_err_d   = !in_range;
        if_rdata_d = in_range ? rd_word : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= P_IF;
      port_q     <= P_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Array has no reset; a reset in ACCESS suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[idx] <= wdata_q;
  end

  assign mem_if.if_ack   = if_ack_q;
  assign mem_if.d_ack    = d_ack_q;
  assign mem_if.if_err   = if_err_q;
  assign mem_if.d_err    = d_err_q;
  assign mem_if.if_rdata = if_rdata_q;
  assign mem_if.d_rdata  = d_rdata_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder (WAIT_CYCLES=1 and =0).
// Random traffic is checked against a word-array reference model.
module tb_mips32_mem_responder;

  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   dual_ack = 0;
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  mips32_mem_responder_if b1 ();
  mips32_mem_responder_if b0 ();

  mips32_mem_responder #(
    .DEPTH(1024), .AW(10), .WAIT_CYCLES(W1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_if(b1), .busy(busy1)
  );

  mips32_mem_responder #(
    .DEPTH(1024), .AW(10), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_if(b0), .busy(busy0)
  );

  always @(negedge clk) begin
    if (b1.if_ack && b1.d_ack) dual_ack++;
    if (b0.if_ack && b0.d_ack) dual_ack++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic access1(input logic port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic scramble,
                         output logic [31:0] rdata, output logic err,
                         output int lat);
    @(posedge clk); #1;
    if (port) begin
      b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata;
    end else begin
      b1.if_req = 1'b1; b1.if_addr = addr;
    end
    lat = -1; rdata = '0; err = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scramble) begin
        b1.d_req = 1'b0; b1.if_req = 1'b0;
        b1.d_addr = $urandom; b1.if_addr = $urandom;
        b1.d_wdata = $urandom; b1.d_we = ~b1.d_we;
      end
      @(negedge clk);
      if (port ? b1.d_ack : b1.if_ack) begin
        lat = k;
        rdata = port ? b1.d_rdata : b1.if_rdata;
        err = port ? b1.d_err : b1.if_err;
      end
    end
    b1.d_req = 1'b0; b1.if_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({b1.if_ack, b1.d_ack, b1.if_err, b1.d_err} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000",
               {b1.if_ack, b1.d_ack, b1.if_err, b1.d_err});
    else pass_cnt++;
    total_cnt++;
    if ({b1.if_rdata, b1.d_rdata} !== 64'h0)
      $display("FAIL reset_rdata got %h want 0", {b1.if_rdata, b1.d_rdata});
    else pass_cnt++;
    total_cnt++;
    if ({busy1, busy0, b0.if_ack, b0.d_ack} !== 4'b0)
      $display("FAIL reset_busy got %b want 0000",
               {busy1, busy0, b0.if_ack, b0.d_ack});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_latency();
    dut1.mem[5] = 32'h2800000A;
    model[5] = 32'h2800000A;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 32'd5;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      total_cnt++;
      if (busy1 !== (k <= 3))
        $display("FAIL fetch_busy c%0d got %b want %b", k, busy1, k <= 3);
      else pass_cnt++;
      total_cnt++;
      if (b1.if_ack !== (k == 3))
        $display("FAIL fetch_ack c%0d got %b want %b", k, b1.if_ack, k == 3);
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++;
        if (b1.if_rdata !== 32'h2800000A || b1.if_err !== 1'b0)
          $display("FAIL fetch_data got %h/%b want 2800000a/0",
                   b1.if_rdata, b1.if_err);
        else pass_cnt++;
        b1.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int lat;
    access1(1'b1, 1'b1, 32'd20, 32'h55, 1'b0, rd, er, lat);
    model[20] = 32'h55;
    total_cnt++;
    if (lat !== W1 + 2 || rd !== 32'h0 || er !== 1'b0)
      $display("FAIL store got lat=%0d rd=%h err=%b want lat=%0d rd=0 err=0",
               lat, rd, er, W1 + 2);
    else pass_cnt++;
    access1(1'b1, 1'b0, 32'd20, 32'h0, 1'b0, rd, er, lat);
    total_cnt++;
    if (lat !== W1 + 2 || rd !== 32'h55 || er !== 1'b0)
      $display("FAIL load got lat=%0d rd=%h err=%b want lat=%0d rd=55 err=0",
               lat, rd, er, W1 + 2);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    int n;
    int base;
    logic exp_port;
    pulse_reset();
    base = dual_ack;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 32'd5;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'd20;
    n = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (b1.if_ack || b1.d_ack) begin
        exp_port = (n % 2 == 0);
        total_cnt++;
        if (b1.d_ack !== exp_port || k !== (W1 + 3) * n + W1 + 2)
          $display("FAIL arb_ack%0d got d=%b cyc=%0d want d=%b cyc=%0d",
                   n, b1.d_ack, k, exp_port, (W1 + 3) * n + W1 + 2);
        else pass_cnt++;
        total_cnt++;
        if ((exp_port ? b1.d_rdata : b1.if_rdata) !==
            (exp_port ? model[20] : model[5]))
          $display("FAIL arb_data%0d got %h/%h", n, b1.d_rdata, b1.if_rdata);
        else pass_cnt++;
        n++;
      end
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    total_cnt++;
    if (n !== 4 || dual_ack !== base)
      $display("FAIL arb_count got acks=%0d dual=%0d want 4/0",
               n, dual_ack - base);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic er;
    int lat;
    dut1.mem[0] = 32'hCAFE0000;
    model[0] = 32'hCAFE0000;
    access1(1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, rd, er, lat);
    total_cnt++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== W1 + 2)
      $display("FAIL oor_store got err=%b rd=%h lat=%0d want 1/0/%0d",
               er, rd, lat, W1 + 2);
    else pass_cnt++;
    access1(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'hCAFE0000 || er !== 1'b0)
      $display("FAIL oor_alias got rd=%h err=%b want cafe0000/0", rd, er);
    else pass_cnt++;
    access1(1'b0, 1'b0, 32'h80000005, 32'h0, 1'b0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h0 || er !== 1'b1)
      $display("FAIL oor_fetch got rd=%h err=%b want 0/1", rd, er);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd;
    logic er;
    int lat;
    dut1.mem[7] = 32'h11111111;
    model[7] = 32'h11111111;
    @(posedge clk); #1;
    b1.d_req = 1'b1; b1.d_we = 1'b1;
    b1.d_addr = 32'd7; b1.d_wdata = 32'h22222222;
    repeat (W1 + 1) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy1 !== 1'b1 || b1.d_ack !== 1'b0)
      $display("FAIL rst_acc_pre got busy=%b ack=%b want 1/0", busy1, b1.d_ack);
    else pass_cnt++;
    rst_n = 1'b0;
    b1.d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({busy1, b1.d_ack, b1.d_err, b1.if_ack} !== 4'b0 || b1.d_rdata !== 0)
      $display("FAIL rst_acc_out got busy=%b ack=%b err=%b rd=%h want 0",
               busy1, b1.d_ack, b1.d_err, b1.d_rdata);
    else pass_cnt++;
    rst_n = 1'b1;
    access1(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, rd, er, lat);
    total_cnt++;
    if (rd !== 32'h11111111)
      $display("FAIL rst_acc_mem got %h want 11111111", rd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, port, we, scr, exp_er;
    int lat;
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      dut1.mem[i] = model[i];
    end
    for (int it = 0; it < 150; it++) begin
      port = 1'($urandom_range(0, 1));
      we = port & 1'($urandom_range(0, 1));
      wd = $urandom;
      scr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        addr = ($urandom & 32'hFFFFFC3F) | 32'h00000400;
      else
        addr = $urandom_range(0, 63);
      exp_er = (addr[31:10] != 0);
      exp_rd = 32'h0;
      if (!exp_er) begin
        if (we) model[addr[9:0]] = wd;
        else exp_rd = model[addr[9:0]];
      end
      access1(port, we, addr, wd, scr, rd, er, lat);
      total_cnt++;
      if (rd !== exp_rd || er !== exp_er || lat !== W1 + 2)
        $display("FAIL rand%0d p=%b we=%b a=%h got rd=%h err=%b lat=%0d want %h/%b/%0d",
                 it, port, we, addr, rd, er, lat, exp_rd, exp_er, W1 + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_wait0();
    logic exp_ack;
    dut0.mem[0] = 32'h00001234;
    @(posedge clk); #1;
    b0.if_req = 1'b1; b0.if_addr = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      exp_ack = (k == 2 || k == 5);
      total_cnt++;
      if (b0.if_ack !== exp_ack)
        $display("FAIL w0_ack c%0d got %b want %b", k, b0.if_ack, exp_ack);
      else pass_cnt++;
      if (k == 2) begin
        total_cnt++;
        if (b0.if_rdata !== 32'h00001234 || b0.if_err !== 1'b0)
          $display("FAIL w0_data got %h/%b want 00001234/0",
                   b0.if_rdata, b0.if_err);
        else pass_cnt++;
      end
      if (k == 5) b0.if_req = 1'b0;
    end
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0;
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b0.if_req = 1'b0; b0.if_addr = '0;
    b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
    test_reset();
    test_fetch_latency();
    test_store_load();
    test_arbitration();
    test_out_of_range();
    test_reset_in_access();
    test_random();
    test_wait0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Word-addressed memory responder serving the pipelined MIPS32 core over two request/acknowledge ports: an instruction-fetch port (read-only) and a data port (LW/SW). It holds a single-ported DEPTH x 32 array and arbitrates between the ports. Each access takes a programmable number of wait states, so the core's fetch and memory stages can be exercised against realistic, non-zero memory latency.

## Interface
- DEPTH, 1024, number of 32-bit words in the array
- AW, 10, word-index width; DEPTH = 2**AW
- WAIT_CYCLES, 1, wait states inserted before each access; legal range 0..15
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  32  fetch word address, as PC
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched instruction, valid while if_ack=1
- if_err  out  1  fetch address out of range, valid while if_ack=1
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store (SW), 0 = load (LW)
- d_addr  in  32  data word address (ALUOUT)
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data, valid while d_ack=1; 0 for stores
- d_err  out  1  data address out of range, valid while d_ack=1
- busy  out  1  1 whenever the FSM is not in IDLE

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
- IDLE
  - If exactly one of d_req/if_req is high, grant that port.
  - If both are high, grant the port not granted last (round-robin). The last-grant register resets to "fetch", so the first tie after reset goes to data.
  - On grant, latch port id, address, d_we and d_wdata. Input changes after the grant edge are ignored.
  - Load the wait counter with WAIT_CYCLES. Next state is WAIT, or ACCESS if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
- ACCESS
  - In range means latched addr[31:AW]==0; the index is addr[AW-1:0].
  - In-range read: register array[index] into the granted port's rdata.
  - In-range write: commit array[index] <= wdata.
  - Out of range: no array write, rdata=0, err=1.
  - Assert the granted port's ack. Next state is DONE.
- DONE: ack, rdata and err are held high/valid for this one cycle. The other port's ack stays 0. Next state is IDLE; no request is accepted in DONE.
- A requester that drops req before ack still gets its transaction completed and acked. No abort is supported.
- Array contents are not initialised by reset. Testbenches preload via hierarchical access.
- Reset (rst_n=0 at a posedge), in any state:
  - state=IDLE, counter=0, last-grant=fetch.
  - if_ack=0, d_ack=0, if_err=0, d_err=0, if_rdata=0, d_rdata=0, busy=0.
  - A write in ACCESS is not committed (reset wins).
  - The array is untouched.

## Timing
- Let cycle 0 be the first cycle in which req is seen in IDLE. ack is high in cycle WAIT_CYCLES+2.
  - WAIT_CYCLES=0: ACCESS in cycle 1, ack in cycle 2.
  - WAIT_CYCLES=1: ack in cycle 3.
- Back-to-back requests on one port: the earliest next acceptance is the cycle after DONE. Period = WAIT_CYCLES+3.
- Store visibility: a load accepted after a store's ack returns the stored value.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, WAIT_CYCLES=1, preload array[5]=32'h2800000A; if_req=1, if_addr=5 -> if_ack high exactly in cycle 3, if_rdata=32'h2800000A, if_err=0, busy high in cycles 1-3.
- d_req=1, d_we=1, d_addr=20, d_wdata=32'h0000_0055, then a load from 20 -> store ack, d_rdata=0; load ack with d_rdata=32'h0000_0055.
- if_req and d_req both high continuously after reset -> grants alternate D, I, D, I; each ack separated by WAIT_CYCLES+3 cycles; no cycle with both acks high.
- d_addr=32'h0000_0400, d_we=1, d_wdata=32'hDEAD_BEEF -> d_ack with d_err=1, d_rdata=0; array[0] unchanged.
- Store to address 7 (array[7] preloaded 32'h1111_1111), rst_n=0 during the ACCESS cycle -> next cycle all outputs 0, state IDLE, array[7] still 32'h1111_1111.
- WAIT_CYCLES=0 build, fetch from 0 -> if_ack in cycle 2; next fetch accepted in cycle 3, acked in cycle 5.
